dbus_sram_responder: RTL
========================

// Module: dbus_sram_responder
// PURPOSE
//  Data-bus responder: the memory-side end of the dbus_req_t/dbus_resp_t protocol the core drives.
//  Backs a word-addressed SRAM window with configurable access latency; answers each request with one data_ok pulse.
//  Used as the data memory in simulation and FPGA builds, in place of the external bus bridge.
// PARAMETERS
//  BASE     64'h8000_0000  byte address of word 0
//  DEPTH    4096           number of 64-bit words (power of 2)
//  LATENCY  2              cycles from request accept to data_ok; legal range 1..15
// PORTS
//  clk          in   1    clock
//  reset        in   1    reset, synchronous, active-high
//  dreq.valid   in   1    request present; core holds all fields stable until data_ok
//  dreq.addr    in   64   byte address
//  dreq.size    in   3    access size; carried only, not used for data steering
//  dreq.data    in   64   write data, already lane-aligned
//  dreq.strobe  in   8    byte enables; all zero means read
//  dresp.data_ok out 1    one-cycle completion pulse
//  dresp.data   out  64   aligned 64-bit word at addr[63:3]; valid only while data_ok
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, data_ok=0, data=0. SRAM contents are not reset.
//  FSM:
//   IDLE -> WAIT when dreq.valid; latch addr/data/strobe; cnt=LATENCY-1 (+jitter).
//   WAIT: if !dreq.valid -> IDLE (abort; no write, no data_ok).
//         elif cnt==0 -> RESP, else cnt--.
//   RESP: data_ok=1 for this cycle only; SRAM read/write happens here; next state IDLE.
//  Acceptance:
//   - A request is accepted only in IDLE, so back-to-back accesses have a one-cycle bubble.
//   - Total latency is LATENCY+1 cycles from first valid to data_ok.
//  Read: data = mem[idx], where idx = (addr-BASE)>>3 (low bits of the word address, DEPTH words).
//  Write (strobe!=0): for each byte b with strobe[b], mem[idx].byte[b] = data.byte[b].
//   - data returns the pre-write word.
//  Out of window (addr<BASE or addr>=BASE+DEPTH*8):
//   - reads return 64'h0; writes are dropped; data_ok is still pulsed.
//  Address math: 64-bit unsigned subtract; compare before the shift; addr[2:0] ignored.
//  Field changes while in WAIT (protocol violation) are ignored; the latched copy is used.
//  Reset asserted mid-WAIT/RESP: return to IDLE next edge; no write committed, no data_ok.
//  data holds its last value outside RESP; it is not cleared.
// CONFIGURATION
//  DBUS_RESP_JITTER_EN defined:
//   - 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5 on reset, steps once per accept.
//   - Load value is cnt = LATENCY-1 + lfsr[1:0] (0..3 extra cycles).
//  Not defined: fixed latency, and no LFSR logic is instantiated.
// STRUCTURE
//  Package dbus_resp_pkg:
//   - dresp_state_t enum {IDLE, WAIT, RESP}
//   - LFSR_SEED=8'hA5, LFSR_TAPS=8'hB8
//   - word-index helper function
//  Sub-module dbus_sram_bank: DEPTH x 64 synchronous array, 1 R/W port, 8 byte-write enables, read-before-write.
//  Top-level: FSM, counter, address decode, LFSR (under the macro).
// TESTING
//  1. Reset, then read 0x8000_0008 with mem[1]=64'hDEAD_BEEF_0123_4567, LATENCY=2 -> data_ok exactly 3 cycles after valid, data matches.
//  2. Write strobe 8'h0F data 64'h1111_2222_3333_4444 to 0x8000_0010 over 64'hFFFF_FFFF_FFFF_FFFF -> readback 64'hFFFF_FFFF_3333_4444.
//  3. Drop valid one cycle into WAIT on a write -> no data_ok; the word is unchanged on readback.
//  4. Read 0x7FFF_FFF8 and read BASE+DEPTH*8 -> data_ok pulsed, data=0; write there leaves mem[0] and mem[DEPTH-1] intact.
//  5. 100 back-to-back reads -> each data_ok is a single-cycle pulse; exactly one bubble between accept windows.
//  6. With DBUS_RESP_JITTER_EN: 256 reads -> latencies in 3..6 cycles, the sequence repeats with period 255, and data stays correct.

Source files
------------

// File: rtl/dbus_resp_pkg.sv
// Shared types for the data-bus SRAM responder: bus structs, FSM state, LFSR constants and address helpers.
package dbus_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dresp_state_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [63:0] data;
      logic [7:0]  strobe;
   } dbus_req_t;

   typedef struct packed {
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Wide enough for LATENCY-1 (max 14) plus up to 3 cycles of jitter.
   localparam int CNT_W = 5;

   function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
      return (addr - base) >> 3;
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Core-to-memory data bus: request struct from the core, response struct back from memory.
interface dbus_sram_responder_if;
   import dbus_resp_pkg::*;

   // Handshake: the master raises dreq.valid with every dreq field and holds them stable
   // until it sees dresp.data_ok; dropping valid earlier abandons the request. data_ok is a
   // one-cycle pulse and dresp.data is meaningful only in that cycle.
   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_sram_bank.sv
// DEPTH x 64-bit synchronous single-port RAM with byte write enables; the read returns the pre-write word.
module dbus_sram_bank #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [7:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata
);

   logic [63:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int b = 0; b < 8; b++) begin
            if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/dbus_sram_responder.sv
// Memory-side responder for the core data bus, backed by an SRAM window with configurable latency.
// Define DBUS_RESP_JITTER_EN to add 0..3 cycles of LFSR-driven latency jitter per request.
module dbus_sram_responder
   import dbus_resp_pkg::*;
#(
   parameter logic [63:0] BASE    = 64'h8000_0000,
   parameter int          DEPTH   = 4096,
   parameter int          LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   dbus_sram_responder_if.slave   dbus,
   output dresp_state_t           dbg_state
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [63:0] WIN_BYTES = 64'(DEPTH) << 3;

   dresp_state_t     state, state_nx;
   logic [CNT_W-1:0] cnt, load_cnt;
   logic [63:0]      addr_q, wdata_q;
   logic [7:0]       strobe_q;
   logic             zero_q;

   logic             accept, fire;
   logic             bank_en;
   logic [7:0]       bank_we;
   logic [63:0]      bank_q;
   logic [63:0]      offset, widx;
   logic             in_win;
   logic             unused_bits;

   // Window decode works on the latched address so mid-WAIT field changes are ignored.
   assign offset = addr_q - BASE;
   assign in_win = (addr_q >= BASE) && (offset < WIN_BYTES);
   assign widx   = word_index(addr_q, BASE);

   assign unused_bits = ^{dbus.dreq.size, widx[63:AW]};

`ifdef DBUS_RESP_JITTER_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset)       lfsr <= LFSR_SEED;
      else if (accept) lfsr <= lfsr_next(lfsr);
   end

   assign load_cnt = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
   assign load_cnt = CNT_W'(LATENCY - 1);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         zero_q <= 1'b1;
      end else begin
         state <= state_nx;
         if (accept)                          cnt <= load_cnt;
         else if (state == WAIT && cnt != '0) cnt <= cnt - CNT_W'(1);
         if (fire)                            zero_q <= ~in_win;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q   <= dbus.dreq.addr;
         wdata_q  <= dbus.dreq.data;
         strobe_q <= dbus.dreq.strobe;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (dbus.dreq.valid) state_nx = WAIT;
         WAIT: begin
            if (!dbus.dreq.valid) state_nx = IDLE;
            else if (cnt == '0)   state_nx = RESP;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The read is issued on the edge into RESP so the word is on the bus during RESP;
   // the write commits on the edge leaving RESP so a reset during RESP drops it.
   always_comb begin
      accept  = 1'b0;
      fire    = 1'b0;
      bank_en = 1'b0;
      bank_we = '0;
      case (state)
         IDLE: accept = dbus.dreq.valid;
         WAIT: begin
            if (dbus.dreq.valid && cnt == '0) begin
               fire    = 1'b1;
               bank_en = in_win && !reset;
            end
         end
         RESP: begin
            if (in_win && strobe_q != '0 && !reset) begin
               bank_en = 1'b1;
               bank_we = strobe_q;
            end
         end
         default: ;
      endcase
   end

   assign dbus.dresp.data_ok = (state == RESP) && !reset;
   assign dbus.dresp.data    = zero_q ? 64'h0 : bank_q;
   assign dbg_state          = state;

   dbus_sram_bank #(.DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .en    (bank_en),
      .we    (bank_we),
      .addr  (widx[AW-1:0]),
      .wdata (wdata_q),
      .rdata (bank_q)
   );

endmodule
